div_gen: RTL and testbench
==========================

Name: div_gen

Overview:
- Parametrised, bus-attached iterative integer divider; next generation of the fixed 32-bit radix-2 divider peripheral.
- Adds configurable operand width and bits-retired-per-cycle, RISC-V-correct signed remainder, and divide-by-zero / signed-overflow detection.
- Also adds a last-operand result cache, sticky done with interrupt, and a single clock domain (bus and datapath both on fclk).
- Sits on the peripheral bus beside the multiplier; software-visible register map is unchanged at offsets 0x00–0x10, with STATUS added at 0x14.

Parameters:
- W, 32, operand width; allowed 8..64; must be a multiple of R.
- R, 1, quotient bits retired per cycle; allowed 1, 2, 4.
- CACHE, 1, 1 = skip recompute when A, B and UNS equal the last completed operation.

Ports:
- fclk  in  1  clock
- frstb  in  1  asynchronous active-low reset
- c_valid  in  1  bus request
- c_write  in  1  1 = write, 0 = read
- c_addr  in  8  byte address; word-aligned; bits [1:0] ignored
- c_wdata  in  W  write data
- c_ready  out  1  response strobe, registered
- c_rdata  out  W  read data, registered
- irq  out  1  level interrupt = DONE & IE

Behaviour:
- Reset (frstb low, async): c_ready=0, c_rdata=0, irq=0; A, B, Q, R, CTL, STATUS, cache registers all 0; FSM=IDLE. Reset mid-calculation aborts; no partial result is kept.
- Bus: c_ready(t+1)=c_valid(t). c_rdata(t+1) is the addressed register when c_valid, else 0. Unmapped addresses read 0 and ignore writes.
- Register map:
  - 0x00 A: dividend, RW.
  - 0x04 B: divisor, RW.
  - 0x08 Q: quotient, RO.
  - 0x0C R: remainder, RO.
  - 0x10 CTL: bit0 START (write-1 pulse, reads 0), bit1 UNS, bit2 IE.
  - 0x14 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear), bit2 DZ (RO), bit3 OVF (RO). DZ and OVF describe the last result.
- While BUSY: writes to A, B and CTL are ignored (c_ready still returned). START is ignored. Reads of Q and R return the previous result.
- FSM states IDLE, CALC, FIX. Edge E0 is the edge that samples a CTL write with START=1 while IDLE.
- Start, special cases checked at E0 in priority order:
  - B==0: Q=all-ones, R=A, DZ=1, OVF=0.
  - Signed, A==MIN, B==-1: Q=MIN, R=0, OVF=1, DZ=0.
  - CACHE and hit: Q and R unchanged; DZ and OVF as last time.
  - In all three cases go to FIX (BUSY=1 after E0); DONE is set at E1.
- Otherwise: load |A| and |B| (raw values if UNS) into the core, clear the remainder accumulator, go to CALC.
- CALC: W/R edges. Each edge performs R restoring steps: shift, compare, subtract, quotient bit=1 on success. Then go to FIX.
- FIX, one edge:
  - Negate Q if signed and A[W-1]^B[W-1].
  - Negate R if signed and A[W-1]; remainder takes the sign of the dividend.
  - Write Q, R, DZ, OVF; update cache with A, B, UNS; set DONE; go to IDLE.
- Latency E0 to DONE visible: W/R+1 edges normal (33 for W=32, R=1); 1 edge for special cases.
- Simultaneous FIX-set of DONE and a W1C write of DONE in the same cycle: set wins.
- A write to CTL with START=0 only updates UNS and IE.
- Cache valid flag is cleared by reset only. A write to A or B changes the compare inputs, so no explicit invalidate is needed.

Decomposition:
- Package div_gen_pkg holds:
  - register offsets (A_OFS..STATUS_OFS)
  - CTL and STATUS bit indices
  - FSM state enum {IDLE, CALC, FIX}
- One sub-module, div_gen_core: W/R-bit iterative unsigned restoring datapath, with load/step controls and an R-deep combinational step chain per cycle.
- Sign handling, special-case detection, cache, FSM and the register file stay in div_gen.

Test Plan:
- W=32, R=1, signed 100/7, START -> DONE after 33 edges; Q=14, R=2; DZ=OVF=0; irq=1 if IE=1.
- Signed -100/7 -> Q=-14, R=-2. Signed 100/-7 -> Q=-14, R=2. Unsigned 0xFFFFFFFF/2 -> Q=0x7FFFFFFF, R=1.
- Div-by-zero: 5/0 -> DONE after 1 edge; Q=0xFFFFFFFF, R=5, DZ=1. Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, OVF=1.
- Cache: repeat 100/7 unchanged -> DONE after 1 edge with same Q and R; toggle UNS -> full 33-edge run.
- W=32, R=4, 1000/3 -> DONE after 9 edges; Q=333, R=1. Write A while BUSY -> A unchanged; START while BUSY ignored.
- Assert frstb low at CALC edge 10 -> all outputs and registers 0, FSM IDLE; a new START after release completes normally. DONE W1C clears DONE and drops irq.

Source files
------------

// File: rtl/div_gen_pkg.sv
// Shared constants for the div_gen bus divider: register offsets, control and
// status bit positions, controller state encoding and start-case encoding.
package div_gen_pkg;

  // Byte offsets of the software-visible registers.
  localparam logic [7:0] A_OFS      = 8'h00;
  localparam logic [7:0] B_OFS      = 8'h04;
  localparam logic [7:0] Q_OFS      = 8'h08;
  localparam logic [7:0] R_OFS      = 8'h0C;
  localparam logic [7:0] CTL_OFS    = 8'h10;
  localparam logic [7:0] STATUS_OFS = 8'h14;

  // CTL register bits.
  localparam int CTL_START = 0;
  localparam int CTL_UNS   = 1;
  localparam int CTL_IE    = 2;

  // STATUS register bits.
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_DZ   = 2;
  localparam int ST_OVF  = 3;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // How the current operation was started; decides what FIX writes back.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,  // normal iterative division
    SP_DZ   = 2'd1,  // divide by zero
    SP_OVF  = 2'd2,  // signed MIN / -1
    SP_HIT  = 2'd3   // operands match the last completed operation
  } div_kind_e;

endpackage

// File: rtl/div_gen_core.sv
// Unsigned restoring divider datapath. A load captures dividend and divisor
// and clears the partial remainder; each step retires R quotient bits through
// a combinational chain of R restoring stages. After W/R steps quot holds the
// quotient and rem the remainder.
module div_gen_core #(
  parameter int W = 32,
  parameter int R = 1
) (
  input  logic         fclk,
  input  logic         frstb,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dvd_in,
  input  logic [W-1:0] dvs_in,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  // quo_q starts as the dividend; its MSBs feed the remainder while quotient
  // bits shift in at the bottom.
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] dvs_q, dvs_d;

  logic [W-1:0] q_t;
  logic [W-1:0] r_t;
  logic [W:0]   trial;
  logic         qbit;

  // Next-state of the datapath: load, or R chained restoring stages per step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    q_t   = quo_q;
    r_t   = rem_q;
    trial = '0;
    qbit  = 1'b0;
    if (load) begin
      quo_d = dvd_in;
      rem_d = '0;
      dvs_d = dvs_in;
    end else if (step) begin
      for (int i = 0; i < R; i++) begin
        // Shifted remainder can exceed W bits, so compare at W+1 bits.
        trial = {r_t, q_t[W-1]};
        if (trial >= {1'b0, dvs_q}) begin
          trial = trial - {1'b0, dvs_q};
          qbit  = 1'b1;
        end else begin
          qbit  = 1'b0;
        end
        r_t = trial[W-1:0];
        q_t = {q_t[W-2:0], qbit};
      end
      quo_d = q_t;
      rem_d = r_t;
    end
  end

  // Datapath registers; reset drops any partial result.
  always_ff @(posedge fclk or negedge frstb) begin
    if (!frstb) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quot = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/div_gen.sv
// Bus-attached iterative integer divider. Holds the register file, special
// case detection (divide by zero, signed overflow, result cache), the
// IDLE/CALC/FIX controller and the sign fix-up around the unsigned core.
// Bus handshake: a request is c_valid for one cycle; c_ready rises exactly
// one cycle later together with c_rdata (the addressed register for any
// request, 0 when no request); there is no back-pressure.
module div_gen
  import div_gen_pkg::*;
#(
  parameter int W     = 32,
  parameter int R     = 1,
  parameter int CACHE = 1
) (
  input  logic         fclk,
  input  logic         frstb,
  input  logic         c_valid,
  input  logic         c_write,
  input  logic [7:0]   c_addr,
  input  logic [W-1:0] c_wdata,
  output logic         c_ready,
  output logic [W-1:0] c_rdata,
  output logic         irq
);

  localparam int STEPS = W / R;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES    = {W{1'b1}};

  // Registers.
  div_state_e   state_q, state_d;
  div_kind_e    kind_q, kind_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic         uns_q, uns_d;
  logic         ie_q, ie_d;
  logic         done_q, done_d;
  logic         dz_q, dz_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] cache_a_q, cache_a_d;
  logic [W-1:0] cache_b_q, cache_b_d;
  logic         cache_uns_q, cache_uns_d;
  logic         cache_vld_q, cache_vld_d;
  logic         c_ready_q, c_ready_d;
  logic [W-1:0] c_rdata_q, c_rdata_d;

  // Decode and control.
  logic [7:0]   addr_w;
  logic         wr, idle;
  logic         wr_a, wr_b, wr_ctl, wr_st;
  logic         start, uns_eff;
  logic         is_dz, is_ovf, is_hit;
  div_kind_e    start_kind;
  logic         core_load, core_step, fix_en;
  logic [W-1:0] a_abs, b_abs;
  logic [W-1:0] core_q, core_r;
  logic [W-1:0] rd_val;

  // Bus decode and start-time special-case detection.
  always_comb begin
    addr_w  = c_addr & 8'hFC;
    wr      = c_valid & c_write;
    idle    = (state_q == IDLE);
    wr_a    = wr && (addr_w == A_OFS);
    wr_b    = wr && (addr_w == B_OFS);
    wr_ctl  = wr && (addr_w == CTL_OFS);
    wr_st   = wr && (addr_w == STATUS_OFS);
    start   = wr_ctl && c_wdata[CTL_START] && idle;
    // The START write carries the UNS bit used by this operation.
    uns_eff = c_wdata[CTL_UNS];
    is_dz   = (b_q == '0);
    is_ovf  = !uns_eff && (a_q == MIN_VAL) && (b_q == ONES);
    is_hit  = (CACHE != 0) && cache_vld_q && (a_q == cache_a_q) &&
              (b_q == cache_b_q) && (uns_eff == cache_uns_q);
    if (is_dz)       start_kind = SP_DZ;
    else if (is_ovf) start_kind = SP_OVF;
    else if (is_hit) start_kind = SP_HIT;
    else             start_kind = SP_NONE;
    // Magnitudes fed to the unsigned core; MIN maps onto itself, which is
    // the correct unsigned magnitude.
    a_abs = (uns_eff || !a_q[W-1]) ? a_q : -a_q;
    b_abs = (uns_eff || !b_q[W-1]) ? b_q : -b_q;
  end

  // Controller state register.
  always_ff @(posedge fclk or negedge frstb) begin
    if (!frstb) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Controller next-state: special cases go straight to FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (start_kind == SP_NONE) ? CALC : FIX;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs.
  always_comb begin
    core_load = (state_q == IDLE) && start && (start_kind == SP_NONE);
    core_step = (state_q == CALC);
    fix_en    = (state_q == FIX);
  end

  div_gen_core #(.W(W), .R(R)) u_core (
    .fclk   (fclk),
    .frstb  (frstb),
    .load   (core_load),
    .step   (core_step),
    .dvd_in (a_abs),
    .dvs_in (b_abs),
    .quot   (core_q),
    .rem    (core_r)
  );

  // Register file, step counter, result write-back and cache update.
  always_comb begin
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    q_d         = q_q;
    r_d         = r_q;
    uns_d       = uns_q;
    ie_d        = ie_q;
    done_d      = done_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_uns_d = cache_uns_q;
    cache_vld_d = cache_vld_q;

    // Operand and control writes only land while idle.
    if (idle) begin
      if (wr_a) a_d = c_wdata;
      if (wr_b) b_d = c_wdata;
      if (wr_ctl) begin
        uns_d = c_wdata[CTL_UNS];
        ie_d  = c_wdata[CTL_IE];
      end
    end

    if (start) kind_d = start_kind;

    if (core_load)                    cnt_d = CW'(STEPS - 1);
    else if (core_step && cnt_q != '0) cnt_d = cnt_q - CW'(1);

    // DONE is write-1-to-clear; the FIX set below overrides a same-cycle clear.
    if (wr_st && c_wdata[ST_DONE]) done_d = 1'b0;

    if (fix_en) begin
      case (kind_q)
        SP_DZ: begin
          q_d   = ONES;
          r_d   = a_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end
        SP_OVF: begin
          q_d   = MIN_VAL;
          r_d   = '0;
          dz_d  = 1'b0;
          ovf_d = 1'b1;
        end
        SP_HIT: begin
          // Q, R, DZ and OVF already describe these operands.
        end
        default: begin
          q_d   = (!uns_q && (a_q[W-1] ^ b_q[W-1])) ? -core_q : core_q;
          r_d   = (!uns_q && a_q[W-1]) ? -core_r : core_r;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
        end
      endcase
      cache_a_d   = a_q;
      cache_b_d   = b_q;
      cache_uns_d = uns_q;
      cache_vld_d = 1'b1;
      done_d      = 1'b1;
    end
  end

  // Read mux and registered bus response.
  always_comb begin
    rd_val = '0;
    case (addr_w)
      A_OFS:   rd_val = a_q;
      B_OFS:   rd_val = b_q;
      Q_OFS:   rd_val = q_q;
      R_OFS:   rd_val = r_q;
      CTL_OFS: begin
        rd_val[CTL_UNS] = uns_q;
        rd_val[CTL_IE]  = ie_q;
      end
      STATUS_OFS: begin
        rd_val[ST_BUSY] = !idle;
        rd_val[ST_DONE] = done_q;
        rd_val[ST_DZ]   = dz_q;
        rd_val[ST_OVF]  = ovf_q;
      end
      default: rd_val = '0;
    endcase
    c_ready_d = c_valid;
    c_rdata_d = c_valid ? rd_val : '0;
  end

  // All non-controller state; asynchronous reset clears everything.
  always_ff @(posedge fclk or negedge frstb) begin
    if (!frstb) begin
      kind_q      <= SP_NONE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      uns_q       <= 1'b0;
      ie_q        <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_uns_q <= 1'b0;
      cache_vld_q <= 1'b0;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
    end else begin
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q_q         <= q_d;
      r_q         <= r_d;
      uns_q       <= uns_d;
      ie_q        <= ie_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_uns_q <= cache_uns_d;
      cache_vld_q <= cache_vld_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
    end
  end

  assign c_ready = c_ready_q;
  assign c_rdata = c_rdata_q;
  assign irq     = done_q & ie_q;

endmodule

// File: tb/tb_div_gen.sv
// Directed bench for div_gen: one R=1 and one R=4 instance, driven through
// their bus ports with hand-computed expected results.
module tb_div_gen;

  localparam logic [7:0] A_A   = 8'h00;
  localparam logic [7:0] A_B   = 8'h04;
  localparam logic [7:0] A_Q   = 8'h08;
  localparam logic [7:0] A_R   = 8'h0C;
  localparam logic [7:0] A_CTL = 8'h10;
  localparam logic [7:0] A_ST  = 8'h14;

  // Index 0 = R=1 instance, index 1 = R=4 instance.
  localparam int D1 = 0;
  localparam int D4 = 1;

  logic        fclk;
  logic        frstb;
  logic        cv   [2];
  logic        cw   [2];
  logic [7:0]  ca   [2];
  logic [31:0] cwd  [2];
  logic        crdy [2];
  logic [31:0] crd  [2];
  logic        irq_s[2];

  int n_cmp = 0;
  int n_mis = 0;

  // Clock and reset.
  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  div_gen #(.W(32), .R(1), .CACHE(1)) dut1 (
    .fclk(fclk), .frstb(frstb), .c_valid(cv[0]), .c_write(cw[0]),
    .c_addr(ca[0]), .c_wdata(cwd[0]), .c_ready(crdy[0]), .c_rdata(crd[0]),
    .irq(irq_s[0])
  );

  div_gen #(.W(32), .R(4), .CACHE(1)) dut4 (
    .fclk(fclk), .frstb(frstb), .c_valid(cv[1]), .c_write(cw[1]),
    .c_addr(ca[1]), .c_wdata(cwd[1]), .c_ready(crdy[1]), .c_rdata(crd[1]),
    .irq(irq_s[1])
  );

  // Scoreboard compare.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks: each transaction occupies exactly one rising edge.
  task automatic bus_write(input int s, input logic [7:0] a, input logic [31:0] d);
    @(negedge fclk);
    cv[s] = 1'b1; cw[s] = 1'b1; ca[s] = a; cwd[s] = d;
    @(posedge fclk);
    #1;
    cv[s] = 1'b0; cw[s] = 1'b0;
  endtask

  task automatic bus_read(input int s, input logic [7:0] a, output logic [31:0] d);
    @(negedge fclk);
    cv[s] = 1'b1; cw[s] = 1'b0; ca[s] = a; cwd[s] = '0;
    @(posedge fclk);
    #1;
    cv[s] = 1'b0;
    d = crd[s];
  endtask

  // Wait (bounded) for irq after a START edge; returns edges counted.
  task automatic wait_done(input int s, output int edges);
    edges = 0;
    while (!irq_s[s] && edges < 200) begin
      @(posedge fclk);
      #1;
      edges++;
    end
  endtask

  // Clear DONE, start with IE=1, and measure edges until DONE.
  task automatic run_op(input int s, input logic uns, output int edges);
    bus_write(s, A_ST, 32'h2);
    bus_write(s, A_CTL, {29'b0, 1'b1, uns, 1'b1});
    wait_done(s, edges);
  endtask

  task automatic chk_qr(input int s, input string tag, input logic [31:0] eq, input logic [31:0] er);
    logic [31:0] d;
    bus_read(s, A_Q, d);
    chk({tag, "_q"}, d, eq);
    bus_read(s, A_R, d);
    chk({tag, "_r"}, d, er);
  endtask

  task automatic chk_all_zero(input int s, input string tag);
    logic [31:0] d;
    bus_read(s, A_A, d);   chk({tag, "_a"}, d, 32'h0);
    bus_read(s, A_B, d);   chk({tag, "_b"}, d, 32'h0);
    bus_read(s, A_Q, d);   chk({tag, "_q"}, d, 32'h0);
    bus_read(s, A_R, d);   chk({tag, "_r"}, d, 32'h0);
    bus_read(s, A_CTL, d); chk({tag, "_ctl"}, d, 32'h0);
    bus_read(s, A_ST, d);  chk({tag, "_st"}, d, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int e;
    frstb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; cw[i] = 1'b0; ca[i] = '0; cwd[i] = '0;
    end

    // Reset state.
    #12;
    chk("rst_ready", {31'b0, crdy[D1]}, 32'h0);
    chk("rst_rdata", crd[D1], 32'h0);
    chk("rst_irq", {31'b0, irq_s[D1]}, 32'h0);
    @(negedge fclk);
    frstb = 1'b1;
    chk_all_zero(D1, "rst");
    chk("ready_after_read", {31'b0, crdy[D1]}, 32'h1);
    @(posedge fclk); #1;
    chk("ready_idle", {31'b0, crdy[D1]}, 32'h0);

    // Signed 100/7.
    bus_write(D1, A_A, 32'd100);
    bus_write(D1, A_B, 32'd7);
    run_op(D1, 1'b0, e);
    chk("s100_7_lat", e, 33);
    chk("s100_7_irq", {31'b0, irq_s[D1]}, 32'h1);
    chk_qr(D1, "s100_7", 32'd14, 32'd2);
    bus_read(D1, A_ST, d);
    chk("s100_7_st", d, 32'h2);

    // Signed -100/7 and 100/-7.
    bus_write(D1, A_A, 32'hFFFF_FF9C);
    run_op(D1, 1'b0, e);
    chk("sm100_7_lat", e, 33);
    chk_qr(D1, "sm100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    bus_write(D1, A_A, 32'd100);
    bus_write(D1, A_B, 32'hFFFF_FFF9);
    run_op(D1, 1'b0, e);
    chk_qr(D1, "s100_m7", 32'hFFFF_FFF2, 32'd2);

    // Unsigned 0xFFFFFFFF/2.
    bus_write(D1, A_A, 32'hFFFF_FFFF);
    bus_write(D1, A_B, 32'd2);
    run_op(D1, 1'b1, e);
    chk("u_ff_2_lat", e, 33);
    chk_qr(D1, "u_ff_2", 32'h7FFF_FFFF, 32'd1);

    // Divide by zero.
    bus_write(D1, A_A, 32'd5);
    bus_write(D1, A_B, 32'd0);
    run_op(D1, 1'b0, e);
    chk("dz_lat", e, 1);
    chk_qr(D1, "dz", 32'hFFFF_FFFF, 32'd5);
    bus_read(D1, A_ST, d);
    chk("dz_st", d, 32'h6);

    // Signed overflow MIN / -1.
    bus_write(D1, A_A, 32'h8000_0000);
    bus_write(D1, A_B, 32'hFFFF_FFFF);
    run_op(D1, 1'b0, e);
    chk("ovf_lat", e, 1);
    chk_qr(D1, "ovf", 32'h8000_0000, 32'h0);
    bus_read(D1, A_ST, d);
    chk("ovf_st", d, 32'hA);

    // Cache: full run, repeat hits, UNS toggle misses.
    bus_write(D1, A_A, 32'd100);
    bus_write(D1, A_B, 32'd7);
    run_op(D1, 1'b0, e);
    chk("cache_fill_lat", e, 33);
    run_op(D1, 1'b0, e);
    chk("cache_hit_lat", e, 1);
    chk_qr(D1, "cache_hit", 32'd14, 32'd2);
    bus_read(D1, A_ST, d);
    chk("cache_hit_st", d, 32'h2);
    run_op(D1, 1'b1, e);
    chk("cache_uns_lat", e, 33);
    chk_qr(D1, "cache_uns", 32'd14, 32'd2);

    // R=4: 1000/3 in 9 edges.
    bus_write(D4, A_A, 32'd1000);
    bus_write(D4, A_B, 32'd3);
    run_op(D4, 1'b0, e);
    chk("r4_lat", e, 9);
    chk_qr(D4, "r4_1000_3", 32'd333, 32'd1);

    // R=4: writes to A and a second START while busy are ignored.
    bus_write(D4, A_A, 32'd2000);
    bus_write(D4, A_ST, 32'h2);
    bus_write(D4, A_CTL, 32'h5);          // E0
    bus_write(D4, A_A, 32'd77);           // E1, busy
    bus_write(D4, A_CTL, 32'h7);          // E2, busy
    bus_read(D4, A_ST, d);                // E3
    chk("r4_busy_st", d, 32'h1);
    bus_read(D4, A_Q, d);                 // E4
    chk("r4_busy_q", d, 32'd333);
    wait_done(D4, e);
    chk("r4_busy_lat", e, 5);
    bus_read(D4, A_A, d);
    chk("r4_busy_a", d, 32'd2000);
    chk_qr(D4, "r4_2000_3", 32'd666, 32'd2);
    bus_read(D4, A_CTL, d);
    chk("r4_busy_ctl", d, 32'h4);

    // Reset at CALC edge 10 aborts; a fresh run then completes.
    bus_write(D1, A_ST, 32'h2);
    bus_write(D1, A_CTL, 32'h5);          // E0, misses cache (UNS differs)
    repeat (10) @(posedge fclk);
    #1;
    frstb = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, crdy[D1]}, 32'h0);
    chk("mid_rst_rdata", crd[D1], 32'h0);
    chk("mid_rst_irq", {31'b0, irq_s[D1]}, 32'h0);
    @(negedge fclk);
    frstb = 1'b1;
    chk_all_zero(D1, "mid_rst");
    bus_write(D1, A_A, 32'd100);
    bus_write(D1, A_B, 32'd7);
    run_op(D1, 1'b0, e);
    chk("post_rst_lat", e, 33);
    chk_qr(D1, "post_rst", 32'd14, 32'd2);

    // DONE write-1-to-clear drops irq.
    bus_write(D1, A_ST, 32'h2);
    chk("w1c_irq", {31'b0, irq_s[D1]}, 32'h0);
    bus_read(D1, A_ST, d);
    chk("w1c_st", d, 32'h0);

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
